fetch_decode_buffer: RTL and testbench

FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_decode_buffer_slot.sv | 37 +++
 rtl/fetch_decode_buffer.sv | 143 ++++++++++++++
 tb/tb_fetch_decode_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and limits for the fetch/decode boundary buffer.
// The bundle struct is sized for the largest supported configuration.
package fetch_pkg;

  localparam int LANES_MAX = 4;
  localparam int XLEN_MAX  = 64;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [32*LANES_MAX-1:0] inst;
    logic [LANES_MAX-1:0]    mask;
    logic [XLEN_MAX-1:0]     pc;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_decode_buffer_slot.sv
// fdb_slot: one bundle storage entry. A clear dominates a load in the same cycle.
// The payload carries no reset; the valid bit alone qualifies it.
module fdb_slot
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_clear,
  input  fetch_bundle_t i_data,
  output logic          o_valid,
  output fetch_bundle_t o_data
);

  logic          r_valid;
  fetch_bundle_t r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_load && !i_clear) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode bundle buffer: depth 1 by default, depth 2 with a registered
// in_ready when FETCH_DECODE_BUFFER_SKID_EN is defined.
module fetch_decode_buffer
  import fetch_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          LANES    = 1,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*LANES-1:0]  in_inst,
  input  logic [LANES-1:0]     in_mask,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  input  logic                 kill_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*LANES-1:0]  out_inst,
  output logic [LANES-1:0]     out_mask,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_pc_next,
  output logic [1:0]           occupancy
);

  fetch_bundle_t w_in_bundle;
  fetch_bundle_t w_head;
  fetch_bundle_t w_data0;
  logic          w_v0;
  logic          w_load0;
  logic          w_clear0;
  logic          w_push;
  logic          w_pop;

  always_comb begin
    w_in_bundle                      = '0;
    w_in_bundle.inst[32*LANES-1:0]   = in_inst;
    w_in_bundle.mask[LANES-1:0]      = in_mask;
    w_in_bundle.pc[XLEN-1:0]         = in_pc;
  end

  // All-zero-mask bundles are accepted but never occupy a slot.
  assign w_pop  = w_v0 && out_ready;
  assign w_push = in_valid && in_ready && !flush && !kill_in && (|in_mask);

  fdb_slot u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load0),
    .i_clear (w_clear0),
    .i_data  (w_data0),
    .o_valid (w_v0),
    .o_data  (w_head)
  );

`ifdef FETCH_DECODE_BUFFER_SKID_EN
  fetch_bundle_t w_tail;
  logic          w_v1;
  logic          w_load1;
  logic          w_clear1;
  logic [1:0]    w_occ_next;
  logic          r_in_ready;

  // Slot 0 is always the head; slot 1 shifts forward when the head drains.
  always_comb begin
    w_load0  = 1'b0;
    w_clear0 = 1'b0;
    w_load1  = 1'b0;
    w_clear1 = 1'b0;
    w_data0  = w_in_bundle;
    if (flush) begin
      w_clear0 = 1'b1;
      w_clear1 = 1'b1;
    end else begin
      if (w_pop && w_v1) begin
        w_load0 = 1'b1;
        w_data0 = w_tail;
      end else if (w_push && (!w_v0 || w_pop)) begin
        w_load0 = 1'b1;
      end else if (w_pop) begin
        w_clear0 = 1'b1;
      end
      if (w_pop) begin
        w_clear1 = 1'b1;
      end else if (w_push && w_v0) begin
        w_load1 = 1'b1;
      end
    end
  end

  fdb_slot u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load1),
    .i_clear (w_clear1),
    .i_data  (w_in_bundle),
    .o_valid (w_v1),
    .o_data  (w_tail)
  );

  assign occupancy  = {1'b0, w_v0} + {1'b0, w_v1};
  assign w_occ_next = flush ? 2'd0 : (occupancy + {1'b0, w_push} - {1'b0, w_pop});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_occ_next < 2'd2);
    end
  end

  assign in_ready = r_in_ready;
`else
  always_comb begin
    w_load0  = 1'b0;
    w_clear0 = 1'b0;
    w_data0  = w_in_bundle;
    if (flush) begin
      w_clear0 = 1'b1;
    end else if (w_push) begin
      w_load0 = 1'b1;
    end else if (w_pop) begin
      w_clear0 = 1'b1;
    end
  end

  assign occupancy = {1'b0, w_v0};
  assign in_ready  = !w_v0 || out_ready;
`endif

  assign out_valid = w_v0;
  assign out_mask  = w_v0 ? w_head.mask[LANES-1:0] : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign out_inst[32*i +: 32] = (w_v0 && w_head.mask[i]) ? w_head.inst[32*i +: 32] : NOP_INST;
  end

  assign out_pc      = w_v0 ? w_head.pc[XLEN-1:0] : '0;
  assign out_pc_next = out_pc + XLEN'(4 * LANES);

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer (LANES=2) against a queue-based model;
// depth follows FETCH_DECODE_BUFFER_SKID_EN.
module tb_fetch_decode_buffer;

  localparam int          XLEN  = 32;
  localparam int          LANES = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_DECODE_BUFFER_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [63:0]       in_inst;
  logic [1:0]        in_mask;
  logic [31:0]       in_pc;
  logic              flush, kill_in;
  logic              out_valid, out_ready;
  logic [63:0]       out_inst;
  logic [1:0]        out_mask;
  logic [31:0]       out_pc, out_pc_next;
  logic [1:0]        occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] inst;
    logic [1:0]  mask;
    logic [31:0] pc;
  } bnd_t;
  bnd_t q[$];

  always #5 clk = ~clk;

  fetch_decode_buffer #(.XLEN(XLEN), .LANES(LANES), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_mask(in_mask), .in_pc(in_pc), .flush(flush), .kill_in(kill_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_mask(out_mask), .out_pc(out_pc), .out_pc_next(out_pc_next),
    .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic bit model_ready(input logic ordy);
    if (DEPTH == 2) return q.size() < 2;
    return (q.size() == 0) || ordy;
  endfunction

  task automatic check_all(input string tag);
    logic [63:0] e_inst;
    logic [1:0]  e_mask;
    logic [31:0] e_pc;
    bit          e_v;
    e_v    = q.size() > 0;
    e_mask = e_v ? q[0].mask : 2'b00;
    e_pc   = e_v ? q[0].pc : 32'h0;
    for (int l = 0; l < LANES; l++)
      e_inst[32*l +: 32] = (e_v && q[0].mask[l]) ? q[0].inst[32*l +: 32] : NOP;
    chk({tag, ".in_ready"},    {63'h0, in_ready},  {63'h0, model_ready(out_ready)});
    chk({tag, ".out_valid"},   {63'h0, out_valid}, {63'h0, e_v});
    chk({tag, ".out_mask"},    {62'h0, out_mask},  {62'h0, e_mask});
    chk({tag, ".out_inst"},    out_inst,           e_inst);
    chk({tag, ".out_pc"},      {32'h0, out_pc},    {32'h0, e_pc});
    chk({tag, ".out_pc_next"}, {32'h0, out_pc_next}, {32'h0, e_pc + 32'd4 * LANES});
    chk({tag, ".occupancy"},   {62'h0, occupancy}, 64'(q.size()));
  endtask

  task automatic step(input string tag, input logic v, input logic [63:0] inst,
                      input logic [1:0] m, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic kl);
    bit   ixfer, oxfer;
    bnd_t b;
    in_valid = v; in_inst = inst; in_mask = m; in_pc = pc;
    out_ready = ordy; flush = fl; kill_in = kl;
    #1;
    check_all(tag);
    ixfer = v && model_ready(ordy);
    oxfer = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (oxfer) void'(q.pop_front());
      if (ixfer && !kl && m != 2'b00) begin
        b.inst = inst; b.mask = m; b.pc = pc;
        q.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b0, 64'h0, 2'b00, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_inst = '0; in_mask = '0; in_pc = '0;
    flush = 0; kill_in = 0; out_ready = 0;
    #2;
    chk("rst.out_valid",   {63'h0, out_valid}, 64'h0);
    chk("rst.out_mask",    {62'h0, out_mask},  64'h0);
    chk("rst.out_inst",    out_inst,           {NOP, NOP});
    chk("rst.out_pc",      {32'h0, out_pc},    64'h0);
    chk("rst.out_pc_next", {32'h0, out_pc_next}, 64'h8);
    chk("rst.occupancy",   {62'h0, occupancy}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst.in_ready", {63'h0, in_ready}, 64'h1);

    // First bundle and its one-cycle latency
    step("first", 1, {32'h1111_2222, 32'h00A0_0093}, 2'b01, 32'h100, 1, 0, 0);
    idle("first.out", 1);

    // Stall for three cycles while offering more bundles
    step("stall.a", 1, 64'hAAAA_0001_BBBB_0001, 2'b11, 32'h200, 0, 0, 0);
    step("stall.b", 1, 64'hAAAA_0002_BBBB_0002, 2'b11, 32'h208, 0, 0, 0);
    step("stall.c", 1, 64'hAAAA_0003_BBBB_0003, 2'b11, 32'h210, 0, 0, 0);
    step("stall.d", 1, 64'hAAAA_0004_BBBB_0004, 2'b11, 32'h218, 0, 0, 0);

    // Flush while full with a bundle offered
    step("flush", 1, 64'hCCCC_0000_DDDD_0000, 2'b11, 32'h300, 0, 1, 0);
    idle("flush.after", 0);

    // Kill the incoming beat while the stored bundle drains
    step("kill.fill", 1, 64'h1234_5678_9ABC_DEF0, 2'b11, 32'h400, 1, 0, 0);
    step("kill", 1, 64'h0FED_CBA9_8765_4321, 2'b11, 32'h408, 1, 0, 1);
    idle("kill.after", 1);

    // Upper lane masked, PC wraps
    step("wrap", 1, 64'hDEAD_BEEF_0000_0013, 2'b01, 32'hFFFF_FFFC, 1, 0, 0);
    idle("wrap.out", 0);
    idle("wrap.drain", 1);

    // All-zero mask is accepted but not stored
    step("zmask", 1, 64'h5555_5555_6666_6666, 2'b00, 32'h500, 1, 0, 0);
    idle("zmask.after", 1);

    // Asynchronous reset between edges with a bundle stored
    step("arst.fill", 1, 64'h7777_0000_8888_0000, 2'b10, 32'h600, 1, 0, 0);
    in_valid = 1; out_ready = 1; in_mask = 2'b11; in_pc = 32'h608;
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out_valid", {63'h0, out_valid}, 64'h0);
    chk("arst.occupancy", {62'h0, occupancy}, 64'h0);
    chk("arst.out_inst",  out_inst,           {NOP, NOP});
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst.in_ready", {63'h0, in_ready}, 64'h1);
    idle("arst.after", 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", $urandom_range(0, 3) != 0, {$urandom, $urandom},
           2'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0);
    end
    idle("end", 1);
    idle("end2", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
